// File: rtl/multiplier_host.sv
// Bus initiator for the shift-add multiplier block: writes M and Q, pulses start,
// waits for ready and reads the 2n-bit product back. Optional macro: READY_SYNC_EN.
module multiplier_host #(
    parameter int n            = 8,
    parameter int START_CYCLES = 16,
    parameter int TIMEOUT      = 1024
) (
    input  logic           clock,
    input  logic           nreset,
    input  logic           req,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*n-1:0] product,
    output logic [1:0]     func,
    output logic           oe,
    output logic           start,
    input  logic           ready,
    inout  wire  [n-1:0]   data
);

    localparam int CW = $clog2(START_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, WR_M, WR_Q, TURN, START, WAIT_ACK, WAIT_RDY, RD_LO, RD_HI, FIN
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  to_q, to_d;
    logic [n-1:0]   a_q, a_d, b_q, b_d, lo_q, lo_d;
    logic [2*n-1:0] product_q, product_d;
    logic           abort_q, abort_d;
    logic           ready_s;
    logic           drv_en;
    logic [n-1:0]   drv_val;

`ifdef READY_SYNC_EN
    logic [1:0] rsync_q, rsync_d;

    // ready comes from a foreign clock domain; two flops before the FSM sees it
    always_comb rsync_d = {rsync_q[0], ready};

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) rsync_q <= '0;
        else         rsync_q <= rsync_d;
    end

    assign ready_s = rsync_q[1];
`else
    assign ready_s = ready;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            to_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            lo_q      <= '0;
            product_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            a_q       <= a_d;
            b_q       <= b_d;
            lo_q      <= lo_d;
            product_q <= product_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        a_d       = a_q;
        b_d       = b_q;
        lo_d      = lo_q;
        product_d = product_q;
        abort_d   = abort_q;
        func      = 2'b10;
        oe        = 1'b0;
        start     = 1'b0;
        drv_en    = 1'b0;
        drv_val   = a_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    a_d     = a;
                    b_d     = b;
                    abort_d = 1'b0;
                    cnt_d   = '0;
                    state_d = WR_M;
                end
            end
            WR_M: begin
                func    = 2'b00;
                drv_en  = 1'b1;
                drv_val = a_q;
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = WR_Q;
                end else cnt_d = cnt_q + 1'b1;
            end
            WR_Q: begin
                func    = 2'b01;
                drv_en  = 1'b1;
                drv_val = b_q;
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = TURN;
                end else cnt_d = cnt_q + 1'b1;
            end
            TURN: state_d = START;
            START: begin
                start = 1'b1;
                if (cnt_q == CW'(START_CYCLES - 1)) begin
                    cnt_d   = '0;
                    to_d    = '0;
                    state_d = WAIT_ACK;
                end else cnt_d = cnt_q + 1'b1;
            end
            WAIT_ACK: begin
                to_d = to_q + 1'b1;
                if (!ready_s) state_d = WAIT_RDY;
                else if (to_q == TW'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    state_d = FIN;
                end
            end
            WAIT_RDY: begin
                to_d = to_q + 1'b1;
                if (ready_s) begin
                    cnt_d   = '0;
                    state_d = RD_LO;
                end else if (to_q == TW'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    state_d = FIN;
                end
            end
            RD_LO: begin
                oe = 1'b1;
                if (cnt_q == CW'(1)) begin
                    lo_d    = data;
                    cnt_d   = '0;
                    state_d = RD_HI;
                end else cnt_d = cnt_q + 1'b1;
            end
            RD_HI: begin
                func = 2'b11;
                oe   = 1'b1;
                // result only becomes visible once both halves are in
                if (cnt_q == CW'(1)) begin
                    product_d = {data, lo_q};
                    cnt_d     = '0;
                    state_d   = FIN;
                end else cnt_d = cnt_q + 1'b1;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign data    = drv_en ? drv_val : {n{1'bz}};
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN) && !abort_q;
    assign err     = (state_q == FIN) && abort_q;
    assign product = product_q;

endmodule

// File: tb/tb_multiplier_host.sv
// Self-checking bench for multiplier_host with a behavioural multiplier target.
module tb_multiplier_host;

    logic        clock = 1'b0;
    logic        nreset = 1'b1;
    logic        req = 1'b0;
    logic [7:0]  op_a = '0, op_b = '0;
    logic        busy, done, err, oe, start;
    logic [15:0] product;
    logic [1:0]  func;
    wire  [7:0]  data;

    logic        tgt_ready = 1'b1;
    logic [7:0]  tgt_m = '0, tgt_q = '0;
    logic [15:0] tgt_p = '0;
    int          deb = 0, comp = 0;
    bit          tgt_hang = 1'b0;
    bit          tb_en = 1'b0;

    int nchk = 0, nbad = 0;
    logic [15:0] exp_prod = '0;
    logic [7:0]  cur_a = '0, cur_b = '0;

    int cyc = 0;
    int n_wrm = 0, n_wrq = 0, n_mbad = 0, n_qbad = 0, n_start = 0;
    int n_lo = 0, n_hi = 0, n_done = 0, n_err = 0, n_acc = 0, n_cont = 0;
    int wack_cyc = 0, err_cyc = 0;
    logic busy_p = 1'b0, start_p = 1'b0;

    always #5 clock = ~clock;

    multiplier_host #(.n(8), .START_CYCLES(16), .TIMEOUT(64)) dut (
        .clock(clock), .nreset(nreset), .req(req), .a(op_a), .b(op_b),
        .busy(busy), .done(done), .err(err), .product(product),
        .func(func), .oe(oe), .start(start), .ready(tgt_ready), .data(data)
    );

    // target: drives the bus only on oe; tb_en lets the bench probe a released bus
    assign data = oe ? ((func == 2'b11) ? tgt_p[15:8] : tgt_p[7:0])
                     : (tb_en ? 8'hA5 : 8'hzz);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!oe && func == 2'b00) tgt_m <= data;
        if (!oe && func == 2'b01) tgt_q <= data;
        deb <= start ? deb + 1 : 0;
        if (start && deb == 7 && tgt_ready && !tgt_hang) begin
            tgt_ready <= 1'b0;
            comp      <= $urandom_range(10, 30);
        end else if (!tgt_ready) begin
            if (comp <= 1) begin
                tgt_ready <= 1'b1;
                tgt_p     <= 16'(tgt_m) * 16'(tgt_q);
            end else comp <= comp - 1;
        end
    end

    always @(negedge clock) begin
        busy_p  <= busy;
        start_p <= start;
        if (!oe && func == 2'b00) begin
            n_wrm <= n_wrm + 1;
            if (data !== cur_a) n_mbad <= n_mbad + 1;
        end
        if (!oe && func == 2'b01) begin
            n_wrq <= n_wrq + 1;
            if (data !== cur_b) n_qbad <= n_qbad + 1;
        end
        if (start) n_start <= n_start + 1;
        if (oe && func == 2'b10) n_lo <= n_lo + 1;
        if (oe && func == 2'b11) n_hi <= n_hi + 1;
        if (done) n_done <= n_done + 1;
        if (err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        if (!start && start_p) wack_cyc <= cyc;
        if (busy && !busy_p) n_acc <= n_acc + 1;
        if (oe && (!func[1] || $isunknown(data))) n_cont <= n_cont + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit hold, input bit hang);
        int s_wrm, s_wrq, s_mbad, s_qbad, s_start, s_lo, s_hi, s_done, s_err, s_acc, s_cont;
        bit seen;
        s_wrm = n_wrm;  s_wrq = n_wrq;  s_mbad = n_mbad; s_qbad = n_qbad;
        s_start = n_start; s_lo = n_lo; s_hi = n_hi; s_done = n_done;
        s_err = n_err;  s_acc = n_acc;  s_cont = n_cont;
        tgt_hang = hang;
        cur_a = x;
        cur_b = y;
        @(negedge clock);
        op_a = x;
        op_b = y;
        req  = 1'b1;
        @(negedge clock);
        if (!hold) req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (done || err) seen = 1'b1;
            else @(negedge clock);
        end
        chk("op_finish", 32'(seen), 32'd1);
        req = 1'b0;
        repeat (4) @(negedge clock);
        if (!hang) exp_prod = 16'(x) * 16'(y);
        chk("product",   32'(product), 32'(exp_prod));
        chk("busy_idle", 32'(busy), 32'd0);
        chk("accepts",   32'(n_acc - s_acc), 32'd1);
        chk("wr_m_cyc",  32'(n_wrm - s_wrm), 32'd2);
        chk("wr_q_cyc",  32'(n_wrq - s_wrq), 32'd2);
        chk("wr_m_data", 32'(n_mbad - s_mbad), 32'd0);
        chk("wr_q_data", 32'(n_qbad - s_qbad), 32'd0);
        chk("start_cyc", 32'(n_start - s_start), 32'd16);
        chk("contention", 32'(n_cont - s_cont), 32'd0);
        if (hang) begin
            chk("to_done",  32'(n_done - s_done), 32'd0);
            chk("to_err",   32'(n_err - s_err), 32'd1);
            chk("to_delay", 32'(err_cyc - wack_cyc), 32'd64);
            chk("to_noread", 32'(n_lo - s_lo + n_hi - s_hi), 32'd0);
        end else begin
            chk("done_cnt", 32'(n_done - s_done), 32'd1);
            chk("err_cnt",  32'(n_err - s_err), 32'd0);
            chk("rd_lo_cyc", 32'(n_lo - s_lo), 32'd2);
            chk("rd_hi_cyc", 32'(n_hi - s_hi), 32'd2);
        end
        tgt_hang = 1'b0;
    endtask

    initial begin
        bit seen;
        #1 nreset = 1'b0;
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_prod",  32'(product), 32'd0);
        chk("rst_func",  32'(func), 32'd2);
        chk("rst_oe",    32'(oe), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        tb_en = 1'b1;
        #1 chk("rst_bus_free", 32'(data), 32'hA5);
        tb_en = 1'b0;
        repeat (2) @(negedge clock);
        nreset = 1'b1;

        run_op(8'd13, 8'd11, 1'b0, 1'b0);
        chk("basic_143", 32'(product), 32'h008F);
        run_op(8'd255, 8'd255, 1'b0, 1'b0);
        chk("max_fe01", 32'(product), 32'hFE01);
        run_op(8'($urandom), 8'($urandom), 1'b1, 1'b0);
        run_op(8'($urandom), 8'($urandom), 1'b0, 1'b1);

        // reset while the host is driving Q onto the bus
        cur_a = 8'h5A;
        cur_b = 8'hC3;
        @(negedge clock);
        op_a = cur_a;
        op_b = cur_b;
        req  = 1'b1;
        @(negedge clock);
        req  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (func == 2'b01) seen = 1'b1;
            else @(negedge clock);
        end
        chk("mid_reach_wrq", 32'(seen), 32'd1);
        #2;
        nreset = 1'b0;
        tb_en  = 1'b1;
        #1;
        exp_prod = '0;
        chk("mid_bus_free", 32'(data), 32'hA5);
        chk("mid_func",  32'(func), 32'd2);
        chk("mid_oe",    32'(oe), 32'd0);
        chk("mid_start", 32'(start), 32'd0);
        chk("mid_busy",  32'(busy), 32'd0);
        chk("mid_prod",  32'(product), 32'(exp_prod));
        tb_en = 1'b0;
        @(negedge clock);
        nreset = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(8'($urandom), 8'($urandom), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule

// File: doc/multiplier_host.md
Name: multiplier_host

Overview:
- Bus initiator that drives the external pin interface of the shift-add multiplier block: func[1:0], oe, start push-button line, ready, and the shared bidirectional data bus.
- Takes two n-bit operands from local logic and writes M, then Q.
- Holds start long enough to pass the multiplier's debouncer, then waits for ready.
- Reads back the low and high product halves and returns a 2n-bit result with a done pulse.

Parameters:
- n, 8, operand width; product width is 2n.
- START_CYCLES, 16, clocks the start line is held high; must exceed the target's debounce count.
- TIMEOUT, 1024, maximum clocks spent in the ready-wait states before aborting with err.

Ports:
- clock, input, 1, system clock; all state updates on its rising edge.
- nreset, input, 1, asynchronous active-low reset.
- req, input, 1, request a multiply; sampled in IDLE only.
- a, input, n, multiplicand; captured on req acceptance.
- b, input, n, multiplier; captured on req acceptance.
- busy, output, 1, high from acceptance until the cycle after done/err.
- done, output, 1, one-cycle pulse when product is valid.
- err, output, 1, one-cycle pulse on timeout; product is not updated.
- product, output, 2n, last good result; held until the next successful operation.
- func, output, 2, target function select: 00 write M, 01 write Q, 10 read low, 11 read high.
- oe, output, 1, target output enable.
- start, output, 1, drives the target's start push-button input.
- ready, input, 1, target ready flag.
- data, inout, n, shared bus; the host drives it only in WR_M and WR_Q, otherwise high-Z.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; func=10, oe=0, start=0; data high-Z; busy=0, done=0, err=0; product=0; all counters 0.
- Idle bus state: func=10, oe=0. Under this setting the target latches nothing and neither side drives the bus.
- FSM states: IDLE, WR_M, WR_Q, TURN, START, WAIT_ACK, WAIT_RDY, RD_LO, RD_HI, FIN.
- IDLE: if req, capture a and b, set busy=1, go to WR_M. req in any other state is ignored and is not queued.
- WR_M, 2 clocks: func=00, data driven with a, oe=0.
- WR_Q, 2 clocks: func=01, data driven with b, oe=0.
- TURN, 1 clock: func=10, oe=0, data released. Guarantees one dead cycle before any target drive.
- START, START_CYCLES clocks: start=1, func=10, oe=0.
- WAIT_ACK: start=0; wait for ready==0, meaning the target has accepted the start.
- WAIT_RDY: wait for ready==1, meaning the product is available.
- Timeout counter: cleared on entry to WAIT_ACK and counts across WAIT_ACK and WAIT_RDY. At TIMEOUT: pulse err, go to FIN without reading.
- RD_LO, 2 clocks: func=10, oe=1. product[n-1:0] is loaded from data at the end of the 2nd clock.
- RD_HI, 2 clocks: func=11, oe=1. product[2n-1:n] is loaded at the end of the 2nd clock.
- Both halves are staged internally; the product register updates only when the read completes successfully.
- FIN, 1 clock: oe=0, func=10; done=1 unless aborted; busy drops next cycle; return to IDLE.
- Ready-transition latency: a ready transition is acted on in the cycle after it is sampled.
- Best-case latency, req to done: 2+2+1+START_CYCLES+1+1+2+2+1 clocks, plus the target's compute time.
- Bus contention rule: the host data driver and oe=1 are never asserted in the same cycle.
- ready glitches: if ready is already low on entry to WAIT_ACK, proceed immediately. If ready returns high during START, it is ignored.
- Reset mid-operation: bus is released and start is dropped asynchronously; the target is left in whatever state it reached.

Optional Feature:
- READY_SYNC_EN defined: ready passes through a two-flop synchronizer before the FSM. This adds 2 clocks to each ready-wait decision. Required when the target runs from an independent oscillator.
- Undefined: ready is used directly. Same-clock target only.

Test Plan:
- Basic multiply: a=13, b=11, req pulse; behavioural target model. Required: bus shows 0x0D with func=00 for 2 clocks, then 0x0B with func=01 for 2 clocks, then start high for exactly 16 clocks. After ready 0→1: product=143 (0x008F), done pulses once, busy falls.
- Max operands: a=255, b=255. Required: product=0xFE01; low half read with func=10, high half with func=11.
- Ignored request: req held high during WAIT_RDY. Required: no second operation starts; after done with req low, IDLE remains.
- Timeout: ready held high forever with TIMEOUT=64. Required: err pulses 64 clocks after WAIT_ACK entry; product unchanged from the previous value; done stays 0.
- Reset mid-write: assert nreset during WR_Q. Required: in the same cycle data goes to Z, func=10, oe=0, start=0, busy=0; the next req runs normally.
- Contention check (all tests): an assertion flags any cycle where the host drives data while oe=1.
